// File: rtl/axi_lite_apb_bridge_if.sv
// AXI4-Lite (slave side) and APB (master side) signal bundle for axi_lite_apb_bridge.
// The slave modport is the bridge's view; master is the view of the surrounding system.
interface axi_lite_apb_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready, prdata, pready, pslverr,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               paddr, psel, penable, pwrite, pwdata, pstrb
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready, prdata, pready, pslverr,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               paddr, psel, penable, pwrite, pwdata, pstrb
    );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one outstanding transfer, round-robin
// read/write arbitration and an ACCESS-phase timeout that forces SLVERR.
module axi_lite_apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    axi_lite_apb_bridge_if.slave bus,
    output logic [2:0]           bridge_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              prio_wr;
    logic [CNT_W-1:0]  wait_cnt;

    logic              wr_req, rd_req, grant_wr, grant_rd, arb_en, done;
    logic [1:0]        resp_next;
    logic [DATA_W-1:0] rdata_next;
    logic [ADDR_W-1:0] req_addr;

    assign bridge_state = state;

    always_comb begin
        wr_req     = bus.awvalid & bus.wvalid;
        rd_req     = bus.arvalid;
        grant_wr   = wr_req & (prio_wr | ~rd_req);
        grant_rd   = rd_req & ~grant_wr;
        // Arbitration also runs on the response handshake so the next request
        // sees its ready in the very first IDLE cycle.
        arb_en     = (state == IDLE && !bus.awready && !bus.arready)
                  || (state == WRESP && bus.bready)
                  || (state == RRESP && bus.rready);
        done       = bus.pready || (wait_cnt == CNT_LAST);
        resp_next  = (bus.pready && !bus.pslverr) ? OKAY : SLVERR;
        rdata_next = bus.pready ? bus.prdata : '0;
        req_addr   = bus.awready ? bus.awaddr : bus.araddr;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            prio_wr     <= 1'b1;
            wait_cnt    <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.arready <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= '0;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= '0;
            bus.rdata   <= '0;
            bus.paddr   <= '0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.pwdata  <= '0;
            bus.pstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.awready || bus.arready) begin
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b0;
                        bus.arready <= 1'b0;
                        bus.paddr   <= req_addr;
                        bus.pwrite  <= bus.awready;
                        bus.pstrb   <= bus.awready ? bus.wstrb : '0;
                        if (bus.awready) bus.pwdata <= bus.wdata;
                        bus.psel    <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        if (bus.pwrite) begin
                            bus.bvalid <= 1'b1;
                            bus.bresp  <= resp_next;
                            state      <= WRESP;
                        end else begin
                            bus.rvalid <= 1'b1;
                            bus.rresp  <= resp_next;
                            bus.rdata  <= rdata_next;
                            state      <= RRESP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WRESP: begin
                    if (bus.bready) begin
                        bus.bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RRESP: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (arb_en) begin
                bus.awready <= grant_wr;
                bus.wready  <= grant_wr;
                bus.arready <= grant_rd;
                if (grant_wr || grant_rd) prio_wr <= ~prio_wr;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Self-checking bench for axi_lite_apb_bridge: transaction-level model of latency,
// responses, APB transfer contents and round-robin grant order.
module tb_axi_lite_apb_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       aclk = 1'b0;
    logic       areset_n;
    logic [2:0] bridge_state;

    always #5 aclk = ~aclk;

    axi_lite_apb_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_lite_apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .bus          (bus.slave),
        .bridge_state (bridge_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_rec_t;

    apb_rec_t    apb_q[$];
    int          apb_wait  = 0;
    bit          apb_err   = 1'b0;
    logic [31:0] apb_rdata = '0;
    bit          prio_m    = 1'b1;

    // APB slave: completes after apb_wait ACCESS wait cycles and logs each transfer.
    initial begin
        int       cnt;
        apb_rec_t snap;
        apb_rec_t rec;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hBAD0_BAD0;
        cnt = 0;
        forever begin
            @(negedge aclk);
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = 32'hBAD0_BAD0;
            if (bus.psel && !bus.penable) begin
                snap.addr  = bus.paddr;
                snap.wr    = bus.pwrite;
                snap.wdata = bus.pwdata;
                snap.strb  = bus.pstrb;
                cnt = 0;
            end else if (bus.psel && bus.penable) begin
                if (cnt == apb_wait) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = apb_err;
                    bus.prdata  = apb_rdata;
                    rec.addr  = bus.paddr;
                    rec.wr    = bus.pwrite;
                    rec.wdata = bus.pwdata;
                    rec.strb  = bus.pstrb;
                    check("apb_stable_addr", {32'd0, rec.addr}, {32'd0, snap.addr});
                    check("apb_stable_ctl", {rec.wr, rec.wdata, rec.strb},
                          {snap.wr, snap.wdata, snap.strb});
                    apb_q.push_back(rec);
                end
                cnt++;
            end
        end
    end

    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int wt, input bit err,
                           input logic [31:0] rd, input int hold);
        bit          tmo;
        logic [1:0]  eresp;
        logic [31:0] erdata;
        int          lat;
        int          n;
        apb_rec_t    r;
        tmo    = (wt >= TO);
        eresp  = (tmo || err) ? 2'b10 : 2'b00;
        erdata = tmo ? 32'd0 : rd;
        apb_wait  = wt;
        apb_err   = err;
        apb_rdata = rd;
        @(negedge aclk);
        if (wr) begin
            bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
            bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        end else begin
            bus.araddr = addr; bus.arvalid = 1'b1;
        end
        n = 0;
        do begin @(negedge aclk); n++; end
        while (!(wr ? bus.awready : bus.arready) && n < 50);
        check("addr_ready", wr ? bus.awready : bus.arready, 1);
        if (wr) check("wready_pair", bus.wready, 1);
        prio_m = ~prio_m;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("setup_phase", {bus.psel, bus.penable}, 2'b10);
        check("setup_ready_low", {bus.awready, bus.wready, bus.arready}, 0);
        if (wr) check("setup_pwdata", bus.pwdata, data);
        @(negedge aclk);
        check("access_phase", {bus.psel, bus.penable}, 2'b11);
        lat = 2;
        while (!(wr ? bus.bvalid : bus.rvalid) && lat < TO + 20) begin
            @(negedge aclk);
            lat++;
        end
        check("latency", lat, tmo ? 2 + TO : 3 + wt);
        check("psel_released", {bus.psel, bus.penable}, 0);
        if (wr) check("bresp", bus.bresp, eresp);
        else    check("rresp_rdata", {bus.rresp, bus.rdata}, {eresp, erdata});
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            if (wr) check("hold_b", {bus.bvalid, bus.bresp}, {1'b1, eresp});
            else    check("hold_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, eresp, erdata});
        end
        if (wr) bus.bready = 1'b1; else bus.rready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        check("valid_drop", wr ? bus.bvalid : bus.rvalid, 0);
        check("back_idle", bridge_state, 0);
        if (tmo) begin
            check("apb_none_on_timeout", apb_q.size(), 0);
        end else begin
            check("apb_count", apb_q.size(), 1);
            if (apb_q.size() > 0) begin
                r = apb_q.pop_front();
                check("apb_paddr", r.addr, addr);
                check("apb_pwrite", r.wr, wr);
                check("apb_pstrb", r.strb, wr ? strb : 4'h0);
                if (wr) check("apb_pwdata", r.wdata, data);
            end
        end
        apb_q.delete();
    endtask

    task automatic serve_one(output bit was_wr);
        int n;
        n = 0;
        do begin @(negedge aclk); n++; end
        while (!(bus.awready || bus.arready) && n < 50);
        check("arb_grant_seen", bus.awready | bus.arready, 1);
        check("arb_single_grant", bus.awready & bus.arready, 0);
        was_wr = bus.awready;
        @(negedge aclk);
        if (was_wr) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
        else bus.arvalid = 1'b0;
        n = 0;
        while (!(was_wr ? bus.bvalid : bus.rvalid) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("arb_resp", was_wr ? bus.bvalid : bus.rvalid, 1);
    endtask

    task automatic run_arb();
        bit w, wr_p, rd_p, exp_wr;
        apb_wait = 0; apb_err = 1'b0; apb_rdata = 32'h0BAD_F00D;
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge aclk);
        bus.awaddr = 32'h2000_0000; bus.wdata = 32'h1357_9BDF; bus.wstrb = 4'hF;
        bus.araddr = 32'h2000_0010;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        wr_p = 1'b1; rd_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_wr = (wr_p && rd_p) ? prio_m : wr_p;
            serve_one(w);
            check("arb_order", w, exp_wr);
            prio_m = ~prio_m;
            if (w) wr_p = 1'b0; else rd_p = 1'b0;
            // Re-present the write while the read is still waiting.
            if (i == 0) begin bus.awvalid = 1'b1; bus.wvalid = 1'b1; wr_p = 1'b1; end
        end
        @(negedge aclk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        check("arb_done_idle", {bus.bvalid, bus.rvalid, bridge_state}, 0);
        apb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  stray;
        areset_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset_ctl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                            bus.psel, bus.penable, bus.pwrite, bus.bresp, bus.rresp}, 0);
        check("reset_data", {bus.rdata, bus.pwdata}, 0);
        check("reset_addr", {bus.paddr, bus.pstrb, bridge_state}, 0);
        areset_n = 1'b1;
        prio_m = 1'b1;

        run_arb();

        do_xfer(1'b1, 32'h1000_0004, 32'h0000_00A5, 4'hF, 0, 1'b0, 32'h0, 0);
        do_xfer(1'b0, 32'h1000_0008, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 5);
        do_xfer(1'b1, 32'h1000_000C, 32'h1234_5678, 4'h3, 2, 1'b1, 32'h0, 1);
        do_xfer(1'b0, 32'h1000_0010, 32'h0, 4'h0, 1, 1'b1, 32'h5555_AAAA, 0);
        do_xfer(1'b0, 32'h1000_0014, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222, 2);
        do_xfer(1'b1, 32'h1000_0018, 32'hCAFE_0001, 4'h8, TO - 1, 1'b0, 32'h0, 0);
        do_xfer(1'b1, 32'h1000_001C, 32'hCAFE_0002, 4'h1, TO, 1'b0, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            do_xfer(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                    $urandom_range(0, TO + 2), ($urandom_range(0, 3) == 0), $urandom(),
                    $urandom_range(0, 3));
        end

        // Reset in the middle of an ACCESS phase that would never complete.
        apb_wait = 1000;
        @(negedge aclk);
        bus.araddr = 32'h3000_0000; bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.arready && n < 50);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.penable && n < 50) begin @(negedge aclk); n++; end
        check("reset_test_in_access", bridge_state, 2);
        #2 areset_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.psel, bus.penable, bus.bvalid, bus.rvalid}, 0);
        check("async_reset_state", bridge_state, 0);
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        prio_m = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            @(negedge aclk);
            if (bus.bvalid || bus.rvalid || bus.psel || bridge_state != 3'd0) stray = 1'b1;
        end
        check("no_stray_after_reset", stray, 0);
        apb_q.delete();

        run_arb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
